// File: rtl/pim_indirect_addr_gen_if.sv
// Request/argument bundle between the argument/LUT register block, the
// indirect address generator and the PIM bank command issuer.
interface pim_indirect_addr_gen_if;
   logic         i_start;
   logic [15:0]  i_bank_mask;
   logic [4:0]   i_num_idx;
   logic [31:0]  i_args_reg_A;
   logic [31:0]  i_args_reg_B;
   logic [31:0]  i_args_reg_C;
   logic [255:0] i_args_reg_LUT_x [15:0];
   logic         i_HPC_clear;
   logic         i_req_ready;
   logic         o_req_valid;
   logic [3:0]   o_req_bank;
   logic [3:0]   o_req_seq;
   logic [31:0]  o_addr_A;
   logic [31:0]  o_addr_B;
   logic [31:0]  o_addr_C;
   logic         o_busy;
   logic         o_done;

   // Host / register-block side
   modport master (
      output i_start, i_bank_mask, i_num_idx, i_args_reg_A, i_args_reg_B,
             i_args_reg_C, i_args_reg_LUT_x, i_HPC_clear, i_req_ready,
      input  o_req_valid, o_req_bank, o_req_seq, o_addr_A, o_addr_B,
             o_addr_C, o_busy, o_done
   );

   // Address generator side
   modport slave (
      input  i_start, i_bank_mask, i_num_idx, i_args_reg_A, i_args_reg_B,
             i_args_reg_C, i_args_reg_LUT_x, i_HPC_clear, i_req_ready,
      output o_req_valid, o_req_bank, o_req_seq, o_addr_A, o_addr_B,
             o_addr_C, o_busy, o_done
   );
endinterface

// File: rtl/pim_indirect_addr_gen.sv
// Indirect address generator: snapshots base registers on start, walks the
// packed 16-bit indices of each selected bank's LUT line and issues one
// gather request per index over a valid/ready handshake.
module pim_indirect_addr_gen #(
   parameter int unsigned IDX_WIDTH  = 16,
   parameter int unsigned NUM_IDX    = 16,
   parameter int unsigned ELEM_SHIFT = 5
) (
   input logic                    clk,
   input logic                    rst_x,
   pim_indirect_addr_gen_if.slave bus
);

   localparam int unsigned LINE_W   = IDX_WIDTH * NUM_IDX;
   localparam int unsigned NUM_BANK = 16;
   localparam int unsigned BANK_W   = 4;
   localparam int unsigned SEQ_W    = 4;
   localparam int unsigned NUM_W    = 5;
   localparam int unsigned GCNT_W   = 8;
   localparam int unsigned ADDR_W   = 32;

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_LOAD, S_ISSUE, S_DONE} state_t;

   state_t              state_r, state_n;
   logic [NUM_BANK-1:0] mask_r, mask_n;
   logic [NUM_W-1:0]    num_r, num_n;
   logic [ADDR_W-1:0]   base_a_r, base_a_n, base_b_r, base_b_n, base_c_r, base_c_n;
   logic [LINE_W-1:0]   shreg_r, shreg_n;
   logic [BANK_W-1:0]   bank_r, bank_n;
   logic [SEQ_W-1:0]    seq_r, seq_n;
   logic [GCNT_W-1:0]   gcnt_r, gcnt_n;
   logic [ADDR_W-1:0]   addr_a_r, addr_a_n, addr_b_r, addr_b_n, addr_c_r, addr_c_n;
   logic                valid_r, valid_n, busy_r, busy_n, done_r, done_n;

   logic                found_c;
   logic [BANK_W-1:0]   sel_bank_c;
   logic [LINE_W-1:0]   line_c;
   logic                last_c;

   // Element byte offset of a zero-extended index
   function automatic logic [ADDR_W-1:0] idx_offs(input logic [IDX_WIDTH-1:0] idx);
      return ADDR_W'(idx) << ELEM_SHIFT;
   endfunction

   // Byte offset of the destination slot for a global request count
   function automatic logic [ADDR_W-1:0] cnt_offs(input logic [GCNT_W-1:0] cnt);
      return ADDR_W'(cnt) << ELEM_SHIFT;
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst_x) begin
      if (rst_x) state_r <= S_IDLE;
      else       state_r <= state_n;
   end

   // Next-state and datapath update
   always_comb begin
      state_n    = state_r;
      mask_n     = mask_r;
      num_n      = num_r;
      base_a_n   = base_a_r;
      base_b_n   = base_b_r;
      base_c_n   = base_c_r;
      shreg_n    = shreg_r;
      bank_n     = bank_r;
      seq_n      = seq_r;
      gcnt_n     = gcnt_r;
      addr_a_n   = addr_a_r;
      addr_b_n   = addr_b_r;
      addr_c_n   = addr_c_r;
      valid_n    = valid_r;
      busy_n     = busy_r;
      done_n     = 1'b0;
      found_c    = 1'b0;
      sel_bank_c = '0;
      line_c     = bus.i_args_reg_LUT_x[bank_r];
      last_c     = (seq_r == SEQ_W'(num_r - NUM_W'(1)));

      for (int i = 0; i < int'(NUM_BANK); i++) begin
         if (mask_r[i] && !found_c) begin
            found_c    = 1'b1;
            sel_bank_c = BANK_W'(i);
         end
      end

      case (state_r)
         S_IDLE: begin
            if (bus.i_start) begin
               mask_n   = bus.i_bank_mask;
               num_n    = (bus.i_num_idx == '0 || 32'(bus.i_num_idx) > NUM_IDX)
                          ? NUM_W'(NUM_IDX) : bus.i_num_idx;
               base_a_n = bus.i_args_reg_A;
               base_b_n = bus.i_args_reg_B;
               base_c_n = bus.i_args_reg_C;
               gcnt_n   = '0;
               busy_n   = 1'b1;
               state_n  = S_SCAN;
            end
         end
         S_SCAN: begin
            if (found_c) begin
               bank_n  = sel_bank_c;
               state_n = S_LOAD;
            end else begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = S_DONE;
            end
         end
         S_LOAD: begin
            shreg_n         = line_c;
            mask_n[bank_r]  = 1'b0;
            seq_n           = '0;
            addr_a_n        = base_a_r + idx_offs(line_c[IDX_WIDTH-1:0]);
            addr_b_n        = base_b_r + idx_offs(line_c[IDX_WIDTH-1:0]);
            addr_c_n        = base_c_r + cnt_offs(gcnt_r);
            valid_n         = 1'b1;
            state_n         = S_ISSUE;
         end
         S_ISSUE: begin
            if (valid_r && bus.i_req_ready) begin
               shreg_n = shreg_r >> IDX_WIDTH;
               seq_n   = seq_r + SEQ_W'(1);
               gcnt_n  = gcnt_r + GCNT_W'(1);
               if (last_c) begin
                  valid_n = 1'b0;
                  state_n = S_SCAN;
               end else begin
                  addr_a_n = base_a_r + idx_offs(shreg_r[IDX_WIDTH +: IDX_WIDTH]);
                  addr_b_n = base_b_r + idx_offs(shreg_r[IDX_WIDTH +: IDX_WIDTH]);
                  addr_c_n = base_c_r + cnt_offs(gcnt_r + GCNT_W'(1));
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Abort wins over start and over an in-flight handshake
      if (bus.i_HPC_clear) begin
         state_n = S_IDLE;
         mask_n  = '0;
         valid_n = 1'b0;
         busy_n  = 1'b0;
         done_n  = 1'b0;
      end
   end

   // Snapshot, walk and output registers
   always_ff @(posedge clk or posedge rst_x) begin
      if (rst_x) begin
         mask_r   <= '0;
         num_r    <= '0;
         base_a_r <= '0;
         base_b_r <= '0;
         base_c_r <= '0;
         shreg_r  <= '0;
         bank_r   <= '0;
         seq_r    <= '0;
         gcnt_r   <= '0;
         addr_a_r <= '0;
         addr_b_r <= '0;
         addr_c_r <= '0;
         valid_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         mask_r   <= mask_n;
         num_r    <= num_n;
         base_a_r <= base_a_n;
         base_b_r <= base_b_n;
         base_c_r <= base_c_n;
         shreg_r  <= shreg_n;
         bank_r   <= bank_n;
         seq_r    <= seq_n;
         gcnt_r   <= gcnt_n;
         addr_a_r <= addr_a_n;
         addr_b_r <= addr_b_n;
         addr_c_r <= addr_c_n;
         valid_r  <= valid_n;
         busy_r   <= busy_n;
         done_r   <= done_n;
      end
   end

   assign bus.o_req_valid = valid_r;
   assign bus.o_req_bank  = bank_r;
   assign bus.o_req_seq   = seq_r;
   assign bus.o_addr_A    = addr_a_r;
   assign bus.o_addr_B    = addr_b_r;
   assign bus.o_addr_C    = addr_c_r;
   assign bus.o_busy      = busy_r;
   assign bus.o_done      = done_r;

endmodule

// File: tb/tb_pim_indirect_addr_gen.sv
// Scoreboard bench for pim_indirect_addr_gen: stimulus pushes expected
// requests, a negedge monitor pops and compares on every handshake.
module tb_pim_indirect_addr_gen;

   typedef struct packed {
      logic [3:0]  bank;
      logic [3:0]  seq;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } req_t;

   logic        clk   = 1'b0;
   logic        rst_x = 1'b1;
   int          checks = 0;
   int          errors = 0;
   int          hs_cnt = 0;
   int          cyc    = 0;
   int          s_cyc  = 0;
   logic [31:0] last_c = '0;
   logic [31:0] ea, eb, ec;
   req_t        exp_q[$];
   req_t        hold_p;
   logic        hold_v = 1'b0;

   pim_indirect_addr_gen_if bus();

   pim_indirect_addr_gen dut (
      .clk   (clk),
      .rst_x (rst_x),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic set_lut(input int b, input int j, input logic [15:0] v);
      bus.i_args_reg_LUT_x[b][j*16 +: 16] = v;
   endtask

   task automatic push(input logic [3:0] bk, input logic [3:0] sq, input logic [15:0] idx, input int g);
      req_t r;
      r.bank = bk;
      r.seq  = sq;
      r.a    = ea + ({16'h0, idx} << 5);
      r.b    = eb + ({16'h0, idx} << 5);
      r.c    = ec + (32'(g) << 5);
      exp_q.push_back(r);
   endtask

   task automatic push_lit(input logic [3:0] bk, input logic [3:0] sq,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      req_t r;
      r.bank = bk;
      r.seq  = sq;
      r.a    = a;
      r.b    = b;
      r.c    = c;
      exp_q.push_back(r);
   endtask

   task automatic start_run(input logic [15:0] mask, input logic [4:0] num);
      @(posedge clk); #1;
      bus.i_bank_mask  = mask;
      bus.i_num_idx    = num;
      bus.i_args_reg_A = ea;
      bus.i_args_reg_B = eb;
      bus.i_args_reg_C = ec;
      bus.i_start      = 1'b1;
      s_cyc            = cyc;
      @(posedge clk); #1;
      bus.i_start      = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int lat);
      int n;
      n   = 0;
      lat = -1;
      while (n < budget && lat < 0) begin
         @(posedge clk); #1;
         n++;
         if (bus.o_done) lat = cyc - s_cyc;
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout budget=%0d", budget);
      end
   endtask

   // Monitor: compare on each handshake, hold-stability under backpressure
   always @(negedge clk) begin
      req_t got;
      req_t e;
      got = '{bank: bus.o_req_bank, seq: bus.o_req_seq,
              a: bus.o_addr_A, b: bus.o_addr_B, c: bus.o_addr_C};
      if (bus.o_req_valid) begin
         if (hold_v) check("stable_under_backpressure", 128'(got), 128'(hold_p));
         if (bus.i_req_ready) begin
            hs_cnt++;
            last_c = bus.o_addr_C;
            hold_v = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req got=%h exp=none", got);
            end else begin
               e = exp_q.pop_front();
               check("req", 128'(got), 128'(e));
            end
         end else begin
            hold_v = 1'b1;
            hold_p = got;
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int hs0;
      int g;
      int n;
      logic seen;

      bus.i_start      = 1'b0;
      bus.i_bank_mask  = '0;
      bus.i_num_idx    = '0;
      bus.i_args_reg_A = '0;
      bus.i_args_reg_B = '0;
      bus.i_args_reg_C = '0;
      bus.i_HPC_clear  = 1'b0;
      bus.i_req_ready  = 1'b0;
      for (int b = 0; b < 16; b++) bus.i_args_reg_LUT_x[b] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 128'({bus.o_req_valid, bus.o_req_bank, bus.o_req_seq, bus.o_addr_A,
                                   bus.o_addr_B, bus.o_addr_C, bus.o_busy, bus.o_done}), 128'(0));
      @(negedge clk) rst_x = 1'b0;

      // T1: single bank, ready held high
      ea = 32'h1000; eb = 32'h2000; ec = 32'h3000;
      set_lut(0, 0, 16'd3); set_lut(0, 1, 16'd0); set_lut(0, 2, 16'd1); set_lut(0, 3, 16'd7);
      set_lut(0, 4, 16'h0055);
      push_lit(4'd0, 4'd0, 32'h1060, 32'h2060, 32'h3000);
      push_lit(4'd0, 4'd1, 32'h1000, 32'h2000, 32'h3020);
      push_lit(4'd0, 4'd2, 32'h1020, 32'h2020, 32'h3040);
      push_lit(4'd0, 4'd3, 32'h10E0, 32'h20E0, 32'h3060);
      bus.i_req_ready = 1'b1;
      hs0 = hs_cnt;
      start_run(16'h0001, 5'd4);
      check("t1_cyc1_valid_busy", 128'({bus.o_req_valid, bus.o_busy}), 128'(2'b01));
      @(posedge clk); #1;
      check("t1_cyc2_valid", 128'(bus.o_req_valid), 128'(0));
      @(posedge clk); #1;
      check("t1_first_valid_lat", 128'({bus.o_req_valid, 32'(cyc - s_cyc)}), 128'({1'b1, 32'd3}));
      wait_done(40, lat);
      check("t1_done_lat", 128'(lat), 128'(8));
      check("t1_busy_at_done", 128'(bus.o_busy), 128'(0));
      @(posedge clk); #1;
      check("t1_done_one_cycle", 128'(bus.o_done), 128'(0));
      check("t1_req_count", 128'(hs_cnt - hs0), 128'(4));
      check("t1_queue_empty", 128'(exp_q.size()), 128'(0));

      // T2: banks 0,2,15 with 16 indices each, ready toggling, snapshot semantics
      for (int j = 0; j < 16; j++) begin
         set_lut(0, j, 16'(j));
         set_lut(2, j, 16'(16'h0100 + j));
         set_lut(15, j, 16'(16'h0AA0 + j));
      end
      g = 0;
      for (int j = 0; j < 16; j++) begin push(4'd0, 4'(j), 16'(j), g); g++; end
      for (int j = 0; j < 16; j++) begin push(4'd2, 4'(j), 16'(16'h0100 + j), g); g++; end
      for (int j = 0; j < 16; j++) begin push(4'd15, 4'(j), 16'(16'hFFF0 + j), g); g++; end
      hs0 = hs_cnt;
      bus.i_req_ready = 1'b1;
      start_run(16'h8005, 5'd0);
      bus.i_args_reg_A = 32'hDEAD_0000;
      for (int j = 0; j < 16; j++) set_lut(15, j, 16'(16'hFFF0 + j));
      n = 0; lat = -1;
      while (n < 400 && lat < 0) begin
         @(posedge clk); #1;
         n++;
         bus.i_req_ready = ~bus.i_req_ready;
         if (n == 6) for (int j = 0; j < 16; j++) set_lut(0, j, 16'hBEEF);
         if (bus.o_done) lat = cyc - s_cyc;
      end
      if (lat < 0) begin checks++; errors++; $display("FAIL t2_done_timeout cycles=%0d", n); end
      check("t2_req_count", 128'(hs_cnt - hs0), 128'(48));
      check("t2_last_addr_C", 128'(last_c), 128'(32'h35E0));
      check("t2_queue_empty", 128'(exp_q.size()), 128'(0));

      // T3: 32-bit wrap and max index
      ea = 32'hFFFF_FFE0; eb = 32'h0; ec = 32'h3000;
      set_lut(1, 0, 16'h0001); set_lut(1, 1, 16'hFFFF);
      push_lit(4'd1, 4'd0, 32'h0000_0000, 32'h0000_0020, 32'h3000);
      push_lit(4'd1, 4'd1, 32'h001F_FFC0, 32'h001F_FFE0, 32'h3020);
      bus.i_req_ready = 1'b1;
      start_run(16'h0002, 5'd2);
      wait_done(40, lat);
      check("t3_done_lat", 128'(lat), 128'(6));
      check("t3_queue_empty", 128'(exp_q.size()), 128'(0));

      // T4: abort on 5th request of bank 2 under backpressure, with simultaneous start
      ea = 32'h1000; eb = 32'h2000; ec = 32'h3000;
      for (int j = 0; j < 4; j++) push(4'd2, 4'(j), 16'(16'h0100 + j), j);
      hs0 = hs_cnt;
      bus.i_req_ready = 1'b1;
      start_run(16'h0004, 5'd8);
      n = 0;
      while (hs_cnt < hs0 + 4 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin checks++; errors++; $display("FAIL t4_wait_timeout hs=%0d", hs_cnt - hs0); end
      bus.i_req_ready = 1'b0;
      check("t4_fifth_req", 128'({bus.o_req_valid, bus.o_req_bank, bus.o_req_seq, bus.o_addr_A, bus.o_addr_B, bus.o_addr_C}),
            128'({1'b1, 4'd2, 4'd4, 32'h3080, 32'h4080, 32'h3080}));
      bus.i_HPC_clear = 1'b1;
      bus.i_start     = 1'b1;
      @(posedge clk); #1;
      bus.i_HPC_clear = 1'b0;
      bus.i_start     = 1'b0;
      check("t4_after_clear", 128'({bus.o_req_valid, bus.o_busy, bus.o_done}), 128'(0));
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.o_done || bus.o_busy || bus.o_req_valid) seen = 1'b1;
      end
      check("t4_quiet_after_clear", 128'(seen), 128'(0));
      check("t4_req_count", 128'(hs_cnt - hs0), 128'(4));
      check("t4_queue_empty", 128'(exp_q.size()), 128'(0));
      push(4'd2, 4'd0, 16'h0100, 0);
      push(4'd2, 4'd1, 16'h0101, 1);
      bus.i_req_ready = 1'b1;
      start_run(16'h0004, 5'd2);
      wait_done(40, lat);
      check("t4_restart_done_lat", 128'(lat), 128'(6));
      check("t4_restart_queue_empty", 128'(exp_q.size()), 128'(0));

      // T5: empty mask
      hs0 = hs_cnt;
      start_run(16'h0000, 5'd0);
      wait_done(10, lat);
      check("t5_empty_done_lat", 128'(lat), 128'(2));
      check("t5_empty_no_req", 128'(hs_cnt - hs0), 128'(0));

      // T5b: start while busy and start during done are ignored
      for (int j = 0; j < 16; j++) begin
         set_lut(0, j, 16'(16'h0010 + j));
         set_lut(1, j, 16'h0777);
      end
      for (int j = 0; j < 3; j++) push(4'd0, 4'(j), 16'(16'h0010 + j), j);
      hs0 = hs_cnt;
      start_run(16'h0001, 5'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.i_bank_mask = 16'h0002;
      bus.i_num_idx   = 5'd16;
      bus.i_start     = 1'b1;
      @(posedge clk); #1;
      bus.i_start     = 1'b0;
      wait_done(40, lat);
      check("t5b_done_lat", 128'(lat), 128'(7));
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      check("t5b_start_at_done_busy", 128'(bus.o_busy), 128'(0));
      @(posedge clk); #1;
      check("t5b_idle_after_done", 128'({bus.o_busy, bus.o_req_valid}), 128'(0));
      repeat (4) @(posedge clk);
      #1;
      check("t5b_req_count", 128'(hs_cnt - hs0), 128'(3));
      check("t5b_queue_empty", 128'(exp_q.size()), 128'(0));

      // T6: asynchronous reset mid-ISSUE
      bus.i_req_ready = 1'b0;
      start_run(16'h0001, 5'd20);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t6_valid_before_reset", 128'({bus.o_req_valid, bus.o_busy}), 128'(2'b11));
      #3;
      rst_x = 1'b1;
      #2;
      check("t6_async_reset", 128'({bus.o_req_valid, bus.o_req_bank, bus.o_req_seq, bus.o_addr_A,
                                    bus.o_addr_B, bus.o_addr_C, bus.o_busy, bus.o_done}), 128'(0));
      @(posedge clk); #3;
      rst_x = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t6_idle_after_release", 128'({bus.o_req_valid, bus.o_busy, bus.o_done}), 128'(0));
      push(4'd0, 4'd0, 16'h0010, 0);
      bus.i_req_ready = 1'b1;
      start_run(16'h0001, 5'd1);
      wait_done(30, lat);
      check("t6_rerun_done_lat", 128'(lat), 128'(5));
      check("t6_rerun_queue_empty", 128'(exp_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pim_indirect_addr_gen.md
Name: pim_indirect_addr_gen

Overview:
- Consumer side of the indirect-addressing argument path.
- Once the host has written base registers A/B/C and per-bank LUT_x lines, this block snapshots them on a start pulse.
- It walks the 16-bit indices packed in each selected bank's LUT line and issues one gather request per index over a valid/ready handshake.
- It sits between the argument/LUT register block and the PIM bank command issuer.

Parameters:
- IDX_WIDTH, 16, bit width of one packed index in a LUT line.
- NUM_IDX, 16, indices per 256-bit LUT line (256/IDX_WIDTH).
- ELEM_SHIFT, 5, log2 of element size in bytes (32 B per index step).

Ports:
- clk  in  1  clock
- rst_x  in  1  reset; asynchronous, active-high (rst_x=1 resets)
- i_start  in  1  one-cycle start pulse
- i_bank_mask  in  16  banks to process; bit n = bank n (bg = n[3:2], bk = n[1:0])
- i_num_idx  in  5  indices per bank; 0 or >16 means 16
- i_args_reg_A  in  32  source-A base address
- i_args_reg_B  in  32  source-B base address
- i_args_reg_C  in  32  destination base address
- i_args_reg_LUT_x  in  256 x16  per-bank LUT lines (unpacked array [15:0])
- i_HPC_clear  in  1  synchronous abort/clear
- i_req_ready  in  1  downstream accepts request
- o_req_valid  out  1  request valid
- o_req_bank  out  4  bank of current request
- o_req_seq  out  4  index position within the bank line
- o_addr_A  out  32  i_args_reg_A + (idx << ELEM_SHIFT)
- o_addr_B  out  32  i_args_reg_B + (idx << ELEM_SHIFT)
- o_addr_C  out  32  i_args_reg_C + (global count << ELEM_SHIFT)
- o_busy  out  1  high from start accept until done
- o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_x=1, async): all outputs 0, state IDLE, counters 0, snapshot registers 0.
- States: IDLE, SCAN, LOAD, ISSUE, DONE.
- IDLE:
  - i_start=1 latches A/B/C, mask, and clamped num_idx, sets o_busy, and goes to SCAN.
  - i_start while busy is ignored.
- SCAN:
  - Selects the lowest set bit of the remaining mask and goes to LOAD.
  - If the remaining mask is empty, goes to DONE. An empty mask at start reaches DONE 2 cycles after start.
- LOAD: copies that bank's LUT line into a 256-bit shift register, clears that mask bit, resets seq to 0, and goes to ISSUE.
- Latency: first o_req_valid appears 3 cycles after the i_start cycle (SCAN, LOAD, then ISSUE asserts valid).
- ISSUE:
  - Index is the shift register [IDX_WIDTH-1:0].
  - Addresses are registered and stable while o_req_valid=1 and i_req_ready=0.
  - Valid never drops without a handshake.
  - On valid&ready: shift right by IDX_WIDTH, seq+1, global count+1.
  - After seq = num_idx-1 handshakes, goes to SCAN, so each bank boundary costs 2 bubble cycles.
  - Ready held high gives one request per cycle within a bank.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE.
- Arithmetic:
  - Index is zero-extended to 32 bits before the shift.
  - All sums wrap modulo 2^32, with no saturation.
  - Global count is 8 bits (max 256) and is never reset between banks within a run.
- Snapshot semantics: LUT lines are sampled in LOAD, not at start. Host writes to a bank's LUT before its LOAD are used; writes after its LOAD are not. A/B/C changes after start have no effect.
- i_HPC_clear=1 in any state:
  - Next cycle is IDLE with o_req_valid=0, o_busy=0, and no o_done pulse.
  - Clear takes priority over a simultaneous i_start and a simultaneous handshake.
- Reset mid-run: immediate return to IDLE; the in-flight request is dropped.
- i_start in the same cycle as o_done is ignored; a new start is accepted only in IDLE.

Test Plan:
- Single bank: A=0x1000, B=0x2000, C=0x3000, mask=0x0001, num_idx=4, LUT[0] low indices {3,0,1,7}, ready=1 -> 4 requests with addr_A 0x1060, 0x1000, 0x1020, 0x10E0; addr_B the same offsets from 0x2000; addr_C 0x3000, 0x3020, 0x3040, 0x3060; bank=0; seq 0..3. First valid 3 cycles after start, o_done 1 cycle after SCAN finds the mask empty.
- Multi-bank order and backpressure: mask=0x8005, num_idx=0 (=16), ready toggling 1/0 -> 48 requests in bank order 0, 2, 15. Outputs are stable across ready=0 cycles. addr_C for the final request is 0x3000 + 47*32 = 0x35E0.
- Wrap-around: A=0xFFFF_FFE0, index 1 -> addr_A=0x0000_0000. Index 0xFFFF, A=0 -> addr_A=0x001F_FFE0.
- Abort: i_HPC_clear asserted during the 5th request of bank 2 while ready=0 -> valid drops next cycle, busy=0, no o_done. A following start runs cleanly from seq 0.
- Edge starts: mask=0 -> o_done 2 cycles after start with no requests. A second i_start during busy is ignored, so the request count is unchanged.
- Async reset asserted mid-ISSUE -> all outputs 0 without a clock edge; after release, the block is IDLE.
